// File: rtl/ad9361_burst_capture.sv
// Burst capture behind the AD9361 filter: snapshots BURST_LEN four-channel words into a FWFT FIFO; input-to-write latency 1 cycle.
// Output is valid/ready; a burst only starts when it fits entirely, so backpressure never truncates one.
// Define AD9361_BURST_TIMESTAMP_EN to prefix every burst with a {magic|seq, timestamp} header word.

module sync_fifo #(
    parameter int W  = 8,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [W-1:0]  wr_dat,
    input  logic          rd_en,
    output logic [W-1:0]  rd_dat,
    output logic          empty,
    output logic [AW:0]   level
);
    localparam int DEPTH = 1 << AW;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wr_dat;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    assign rd_dat = mem[rd_ptr];
    assign empty  = (level == '0);
endmodule

module ad9361_burst_capture #(
    parameter int BURST_LEN       = 64,
    parameter int LOG2_FIFO_DEPTH = 8,
    parameter int HOLDOFF         = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       enable,
    input  logic                       valid_0_in,
    input  logic                       valid_1_in,
    input  logic                       valid_2_in,
    input  logic                       valid_3_in,
    input  logic [11:0]                data_i0_in,
    input  logic [11:0]                data_q0_in,
    input  logic [11:0]                data_i1_in,
    input  logic [11:0]                data_q1_in,
    input  logic [11:0]                data_i2_in,
    input  logic [11:0]                data_q2_in,
    input  logic [11:0]                data_i3_in,
    input  logic [11:0]                data_q3_in,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [95:0]                out_data,
    output logic [3:0]                 out_mask,
    output logic                       out_last,
    output logic                       out_hdr,
    output logic                       busy,
    output logic [15:0]                drop_count,
    output logic [LOG2_FIFO_DEPTH:0]   fifo_level
);
    localparam int DEPTH = 1 << LOG2_FIFO_DEPTH;
`ifdef AD9361_BURST_TIMESTAMP_EN
    localparam int SPACE = BURST_LEN + 1;
`else
    localparam int SPACE = BURST_LEN;
`endif
    localparam int LW = LOG2_FIFO_DEPTH + 1;
    localparam int CW = $clog2(BURST_LEN + HOLDOFF + 1);
    localparam logic [LW-1:0] DEPTH_W  = LW'(DEPTH);
    localparam logic [LW-1:0] SPACE_W  = LW'(SPACE);
    localparam logic [CW-1:0] LAST_IDX = CW'(BURST_LEN - 1);
    localparam logic [CW-1:0] HOLD_END = CW'(HOLDOFF - 1);

    typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_HOLDOFF} state_t;

    typedef struct packed {
        logic        hdr;
        logic        last;
        logic [3:0]  mask;
        logic [95:0] dat;
    } word_t;

    state_t        state;
    logic [CW-1:0] cnt;
    word_t         stg;
    logic          stg_vld;
    word_t         wr_word;
    word_t         head;
    logic          wr_en;
    logic          fifo_empty;
    logic          trig;
    logic          space_ok;
    logic          accept;
    logic [3:0]    samp_mask;
    logic [95:0]   samp_dat;

    assign samp_mask = {valid_3_in, valid_2_in, valid_1_in, valid_0_in};
    assign samp_dat  = {data_i0_in, data_q0_in, data_i1_in, data_q1_in,
                        data_i2_in, data_q2_in, data_i3_in, data_q3_in};
    assign trig      = enable & (|samp_mask);
    // Stage register is always empty in IDLE, so fifo_level is the exact occupancy here.
    assign space_ok  = (DEPTH_W - fifo_level) >= SPACE_W;
    assign accept    = (state == S_IDLE) && trig && space_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            stg        <= '0;
            stg_vld    <= 1'b0;
            drop_count <= '0;
        end else begin
            stg_vld <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (trig && space_ok) begin
                        stg_vld  <= 1'b1;
                        stg.hdr  <= 1'b0;
                        stg.last <= (BURST_LEN == 1);
                        stg.mask <= samp_mask;
                        stg.dat  <= samp_dat;
                        cnt      <= (BURST_LEN == 1) ? '0 : CW'(1);
                        state    <= (BURST_LEN == 1) ? S_HOLDOFF : S_CAPTURE;
                    end else if (trig) begin
                        if (drop_count != 16'hFFFF) drop_count <= drop_count + 1'b1;
                        cnt   <= '0;
                        state <= S_HOLDOFF;
                    end
                end
                S_CAPTURE: begin
                    stg_vld  <= 1'b1;
                    stg.hdr  <= 1'b0;
                    stg.last <= (cnt == LAST_IDX);
                    stg.mask <= samp_mask;
                    stg.dat  <= samp_dat;
                    if (cnt == LAST_IDX) begin
                        cnt   <= '0;
                        state <= S_HOLDOFF;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_HOLDOFF: begin
                    if (cnt == HOLD_END) begin
                        cnt   <= '0;
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef AD9361_BURST_TIMESTAMP_EN
    logic [63:0] ts;
    logic [15:0] burst_seq;
    word_t       hdr_word;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts        <= '0;
            burst_seq <= '0;
        end else begin
            ts <= ts + 1'b1;
            if (accept) burst_seq <= burst_seq + 1'b1;
        end
    end

    // Header bypasses the stage register so it lands one cycle ahead of sample 0.
    assign hdr_word = '{hdr: 1'b1, last: 1'b0, mask: 4'h0, dat: {16'hA5A5, burst_seq, ts}};
    assign wr_en    = stg_vld | accept;
    assign wr_word  = accept ? hdr_word : stg;
`else
    assign wr_en    = stg_vld;
    assign wr_word  = stg;
`endif

    sync_fifo #(
        .W  ($bits(word_t)),
        .AW (LOG2_FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .wr_en  (wr_en),
        .wr_dat (wr_word),
        .rd_en  (out_valid & out_ready),
        .rd_dat (head),
        .empty  (fifo_empty),
        .level  (fifo_level)
    );

    assign out_valid = ~fifo_empty;
    assign out_data  = out_valid ? head.dat  : '0;
    assign out_mask  = out_valid ? head.mask : '0;
    assign out_last  = out_valid & head.last;
    assign out_hdr   = out_valid & head.hdr;
    assign busy      = (state != S_IDLE);
endmodule

// File: doc/ad9361_burst_capture.md
# ad9361_burst_capture

Burst capture stage directly downstream of the AD9361 sample filter. Watches the four filtered per-channel valid strobes and, on the first qualified sample, snapshots a fixed-length burst of all four channels' I/Q into an internal FIFO. The FIFO is drained through a valid/ready stream toward the host DMA packer. Bursts are only started when the whole burst fits, so a burst is never truncated by overflow.

## Interface
- BURST_LEN, 64: sample words per burst (1..2^LOG2_FIFO_DEPTH, minus 1 with timestamp).
- LOG2_FIFO_DEPTH, 8: FIFO depth is 2^LOG2_FIFO_DEPTH words.
- HOLDOFF, 16: idle cycles after a burst or drop before re-trigger (>=1).
- clk  in  1  sole clock.
- rst_n  in  1  one clock; reset is asynchronous and active-low.
- enable  in  1  arms triggering; sampled only in IDLE.
- valid_0_in..valid_3_in  in  1 each  filtered per-channel sample valid.
- data_i0_in..data_q3_in  in  12 each  per-channel I/Q, two's complement.
- out_valid  out  1  FIFO head word present.
- out_ready  in  1  consumer accepts head word.
- out_data  out  96  {i0,q0,i1,q1,i2,q2,i3,q3}, i0 at [95:84], q3 at [11:0].
- out_mask  out  4  captured valid_k_in per word, bit k = channel k.
- out_last  out  1  final sample word of a burst.
- out_hdr  out  1  word is a timestamp header (always 0 without the macro).
- busy  out  1  state is not IDLE.
- drop_count  out  16  bursts refused for lack of space, saturates at 16'hFFFF.
- fifo_level  out  LOG2_FIFO_DEPTH+1  words currently in FIFO.

## Operation
- States: IDLE, CAPTURE, HOLDOFF.
- IDLE: trigger = enable & (any valid_k_in). Needed space S = BURST_LEN (+1 with timestamp). If trigger and 2^LOG2_FIFO_DEPTH - fifo_level >= S -> CAPTURE, else if trigger -> drop_count++ (saturating), -> HOLDOFF.
- CAPTURE: trigger-cycle sample is sample 0; captures BURST_LEN consecutive cycles unconditionally (out_mask records which channels were valid). Sample counter reaching BURST_LEN-1 -> HOLDOFF. enable is ignored here; a burst always completes.
- HOLDOFF: counts HOLDOFF cycles, then -> IDLE.
- Inputs pass through one register stage before the FIFO write port.
- FIFO: first-word-fall-through; transfer on out_valid & out_ready; out_ready ignored when empty. Simultaneous read and write in one cycle leave fifo_level unchanged. Space check guarantees no write when full.
- out_last set only on sample BURST_LEN-1; header words have out_last=0, out_mask=0.
- Reset: state IDLE, counters 0, FIFO emptied, timestamp 0; out_valid, out_last, out_hdr, busy = 0, out_data/out_mask = 0, drop_count = 0, fifo_level = 0. Reset mid-burst discards the partial burst.

## Timing
- Trigger in cycle t: busy high from t+1.
- Sample k written at end of cycle t+1+k; with empty FIFO and out_ready=1, sample 0 has out_valid in cycle t+2, sample k in cycle t+2+k.
- Header (timestamp build) written at end of cycle t; out_valid in cycle t+1.
- Last write at end of t+BURST_LEN; state IDLE again at t+BURST_LEN+HOLDOFF.
- fifo_level updates the cycle after the write/read edge.
- Throughput: one word per cycle in and out.

## Configuration
- AD9361_BURST_TIMESTAMP_EN defined: 64-bit free-running cycle counter (clears on reset, wraps). Each burst is preceded by one header word: out_data = {32'hA5A5_0000 | burst_seq[15:0], timestamp at trigger cycle t}, out_hdr=1; burst_seq increments per accepted burst, wraps; S = BURST_LEN+1.
- Not defined: no counter, no header, out_hdr tied 0, S = BURST_LEN.

## Test plan
- BURST_LEN=8, enable=1, valid_2_in pulsed one cycle with ramp data, out_ready=1 -> 8 words, out_mask[2] only on word 0, out_last on word 7, first out_valid at t+2 (t+1 header with macro).
- Continuous valid on all channels, HOLDOFF=16 -> bursts spaced BURST_LEN+HOLDOFF cycles, none lost, drop_count=0.
- out_ready=0, LOG2_FIFO_DEPTH=4, BURST_LEN=8 -> two bursts fill 16 words; third trigger refused, drop_count=1, fifo_level=16; release out_ready -> 16 words in order.
- enable dropped in cycle t+3 of a burst -> burst still completes with 8 words; no new trigger while enable=0.
- rst_n asserted mid-CAPTURE with 5 words queued -> out_valid=0, fifo_level=0, busy=0 immediately; next trigger starts a clean burst (header timestamp restarts from 0 with macro).
- Random out_ready backpressure over 1000 bursts -> scoreboard matches every word, mask and out_last exactly.
